// File: rtl/mlp_pkg.sv
// Shared constants, word type and controller state encoding for the MLP frame
// controller and its argmax sequencer.
package mlp_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int WR_IDX_W    = 10;
  localparam int CLS_W       = 4;
  localparam int SETTLE_W    = 8;

  // Bit [0] is the MSB of every pixel and score word.
  typedef logic [0:DATA_W-1] word_t;

  typedef enum logic [1:0] {
    FILL,
    SETTLE,
    ARGMAX,
    OUTPUT
  } ctrl_state_t;

endpackage

// File: rtl/mlp_argmax_seq.sv
// Sequential argmax over the network scores: one class per cycle after start,
// signed strict compare so ties keep the lowest index; done pulses once at the end.
module mlp_argmax_seq
  import mlp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  word_t            result [NUM_CLASSES],
  output logic             done,
  output logic [CLS_W-1:0] idx,
  output word_t            score
);

  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);

  logic             busy;
  logic [CLS_W-1:0] cls;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cls   <= '0;
      done  <= 1'b0;
      idx   <= '0;
      score <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cls  <= '0;
      end else if (busy) begin
        // Class 0 seeds the running best unconditionally.
        if (cls == '0 || $signed(result[cls]) > $signed(score)) begin
          idx   <= cls;
          score <= result[cls];
        end
        if (cls == CLS_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cls <= cls + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mlp_frame_controller.sv
// Frame controller: streams a picture into the network input buffer, lets the
// network settle, argmaxes its scores and returns the digit over a handshake.
module mlp_frame_controller
  import mlp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  word_t            pix_data,
  input  logic             pix_last,
  output word_t            picture [NUM_PIXELS],
  input  word_t            result [NUM_CLASSES],
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic [CLS_W-1:0] digit,
  output word_t            digit_score,
  output logic             frame_err
);

  ctrl_state_t         state, state_next;
  logic [WR_IDX_W-1:0] wr_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                pix_accept;
  logic                last_idx;
  logic                argmax_start;
  logic                argmax_done;
  logic [CLS_W-1:0]    argmax_idx;
  word_t               argmax_score;

  assign pix_ready   = (state == FILL);
  assign digit_valid = (state == OUTPUT);
  assign pix_accept  = pix_valid & pix_ready;
  assign last_idx    = (wr_idx == WR_IDX_W'(NUM_PIXELS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    argmax_start = 1'b0;
    case (state)
      FILL:   if (pix_accept && last_idx) state_next = SETTLE;
      SETTLE: if (settle_cnt == '0) begin
                state_next   = ARGMAX;
                argmax_start = 1'b1;
              end
      ARGMAX: if (argmax_done) state_next = OUTPUT;
      OUTPUT: if (digit_ready) state_next = FILL;
    endcase
  end

  // A full frame completes on the last index whatever pix_last says; a stray
  // pix_last earlier discards the frame. Either mismatch is a framing error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      settle_cnt  <= '0;
      frame_err   <= 1'b0;
      digit       <= '0;
      digit_score <= '0;
    end else begin
      frame_err <= pix_accept & (last_idx ^ pix_last);
      if (pix_accept) wr_idx <= (last_idx || pix_last) ? '0 : wr_idx + 1'b1;
      if (pix_accept && last_idx)
        settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
      if (state == ARGMAX && argmax_done) begin
        digit       <= argmax_idx;
        digit_score <= argmax_score;
      end
    end
  end

  // NOTE: the picture buffer is a register array feeding the network directly,
  // so it must be cleared explicitly on reset rather than left as RAM contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) picture[i] <= '0;
    end else if (pix_accept) begin
      picture[wr_idx] <= pix_data;
    end
  end

  mlp_argmax_seq u_argmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (argmax_start),
    .result (result),
    .done   (argmax_done),
    .idx    (argmax_idx),
    .score  (argmax_score)
  );

endmodule

// File: tb/tb_mlp_frame_controller.sv
// Self-checking bench for mlp_frame_controller: randomized frames and scores
// compared against a behavioural picture/argmax/latency model.
module tb_mlp_frame_controller;
  import mlp_pkg::*;

  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + NUM_CLASSES + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        digit_ready = 1'b0;
  word_t       pix_data = '0;
  word_t       picture [NUM_PIXELS];
  word_t       result [NUM_CLASSES];
  logic        pix_ready, digit_valid, frame_err;
  logic [3:0]  digit;
  word_t       digit_score;

  logic [15:0] pic_model [NUM_PIXELS];
  logic [15:0] res_m [NUM_CLASSES];
  int          checks = 0;
  int          errors = 0;
  int          ferr_cnt = 0;
  int          dv_cnt = 0;
  time         ferr_t = 0;
  time         t_last = 0;

  mlp_frame_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .picture     (picture),
    .result      (result),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit       (digit),
    .digit_score (digit_score),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) begin
      ferr_cnt++;
      ferr_t = $time;
    end
    if (digit_valid) dv_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd_score();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic apply_results();
    for (int i = 0; i < NUM_CLASSES; i++) result[i] = res_m[i];
  endtask

  task automatic random_results();
    for (int i = 0; i < NUM_CLASSES; i++) res_m[i] = rnd_score();
    apply_results();
  endtask

  // Reference: maximum signed value, then the first class holding it.
  task automatic ref_argmax(output int e_idx, output logic [15:0] e_sc);
    int mx;
    int v;
    mx = -32768;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      v = int'($signed(res_m[i]));
      if (v > mx) mx = v;
    end
    e_idx = 0;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      v = int'($signed(res_m[i]));
      if (v == mx) e_idx = i;
    end
    e_sc = 16'(mx);
  endtask

  function automatic int pic_mismatch();
    int m;
    logic [15:0] v;
    m = 0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      v = picture[i];
      if (v !== pic_model[i]) m++;
    end
    return m;
  endfunction

  // Beats first..n-1 go to picture[first..n-1]; pix_last is raised on beat last_at.
  task automatic send_frame(input int first, input int n, input int last_at,
                            input bit rnd, input logic [15:0] val);
    logic [15:0] d;
    int g;
    for (int i = first; i < n; i++) begin
      d = rnd ? 16'($urandom) : val;
      if (rnd && $urandom_range(0, 15) == 0) begin
        @(negedge clk);
        pix_valid = 1'b0;
      end
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = (i == last_at);
      g = 0;
      while (!pix_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g == 50) check("pix_ready_timeout", 32'(pix_ready), 32'd1);
      @(posedge clk);
      pic_model[i] = d;
      t_last = $time;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_digit(output int e_idx, output logic [15:0] e_sc);
    int g;
    int lat;
    ref_argmax(e_idx, e_sc);
    g = 0;
    while (!digit_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    lat = int'(($time - t_last - 5) / 10);
    check("latency", 32'(lat), 32'(LAT));
    check("digit", 32'(digit), 32'(e_idx));
    check("digit_score", 32'(digit_score), 32'(e_sc));
  endtask

  task automatic ack(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("valid_hold", 32'(digit_valid), 32'd1);
    end
    digit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    digit_ready = 1'b0;
    check("valid_drop", 32'(digit_valid), 32'd0);
    check("ready_back", 32'(pix_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_PIXELS; i++) pic_model[i] = '0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
    check({tag, "_digit_valid"}, 32'(digit_valid), 32'd0);
    check({tag, "_digit"}, 32'(digit), 32'd0);
    check({tag, "_score"}, 32'(digit_score), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_picture"}, 32'(pic_mismatch()), 32'd0);
  endtask

  task automatic no_digit_window(input string tag);
    int d0;
    d0 = dv_cnt;
    repeat (30) @(negedge clk);
    check(tag, 32'(dv_cnt - d0), 32'd0);
  endtask

  initial begin
    int          ei;
    int          f0;
    logic [15:0] es;
    logic [15:0] bp;

    for (int i = 0; i < NUM_CLASSES; i++) res_m[i] = 16'h0100;
    apply_results();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    reset_checks("reset");

    // Constant frame, class 7 wins.
    res_m[7] = 16'h0500;
    apply_results();
    f0 = ferr_cnt;
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, 16'h0100);
    wait_digit(ei, es);
    check("t1_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("t1_picture", 32'(pic_mismatch()), 32'd0);
    ack(0);

    // Negative scores with a tie between classes 3 and 8.
    for (int i = 0; i < NUM_CLASSES; i++) res_m[i] = 16'hFF00;
    res_m[3] = 16'h0002;
    res_m[8] = 16'h0002;
    apply_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("t2_tie_idx", 32'(digit), 32'd3);
    ack(2);

    // All scores at the most negative value.
    for (int i = 0; i < NUM_CLASSES; i++) res_m[i] = 16'h8000;
    apply_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("t3_min_score", 32'(digit_score), 32'h8000);
    ack(1);

    // Early pix_last on beat 99, then a clean frame.
    f0 = ferr_cnt;
    send_frame(0, 100, 99, 1'b1, 16'h0);
    no_digit_window("t4_no_digit");
    check("t4_err_count", 32'(ferr_cnt - f0), 32'd1);
    check("t4_err_time", 32'(ferr_t - t_last), 32'd5);
    random_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("t4_picture", 32'(pic_mismatch()), 32'd0);
    ack(0);

    // Missing pix_last on the final beat.
    random_results();
    f0 = ferr_cnt;
    send_frame(0, NUM_PIXELS, -1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("t5_err_count", 32'(ferr_cnt - f0), 32'd1);
    check("t5_err_time", 32'(ferr_t - t_last), 32'd5);
    ack(0);

    // Backpressure with a pixel beat waiting during OUTPUT.
    random_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    bp = 16'($urandom);
    pix_valid = 1'b1;
    pix_data  = bp;
    pix_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_digit", 32'(digit), 32'(ei));
      check("bp_score", 32'(digit_score), 32'(es));
      check("bp_pix_ready", 32'(pix_ready), 32'd0);
    end
    digit_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    digit_ready = 1'b0;
    check("bp_valid_drop", 32'(digit_valid), 32'd0);
    check("bp_ready_back", 32'(pix_ready), 32'd1);
    @(posedge clk);
    pic_model[0] = bp;
    @(negedge clk);
    pix_valid = 1'b0;
    random_results();
    send_frame(1, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("bp_picture", 32'(pic_mismatch()), 32'd0);
    ack(0);

    // Random frames, scores and acknowledge delays.
    for (int k = 0; k < 3; k++) begin
      random_results();
      send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
      wait_digit(ei, es);
      check("rnd_picture", 32'(pic_mismatch()), 32'd0);
      ack(int'($urandom_range(0, 5)));
    end

    // Reset while the argmax is running.
    for (int i = 0; i < NUM_CLASSES; i++) res_m[i] = 16'h0010;
    res_m[9] = 16'h0400;
    apply_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    repeat (8) @(negedge clk);
    do_reset();
    reset_checks("rst_argmax");
    no_digit_window("rst_argmax_no_digit");

    // Reset partway through filling, then a clean frame.
    send_frame(0, 400, -1, 1'b1, 16'h0);
    do_reset();
    reset_checks("rst_fill");
    no_digit_window("rst_fill_no_digit");
    random_results();
    send_frame(0, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, 16'h0);
    wait_digit(ei, es);
    check("post_rst_picture", 32'(pic_mismatch()), 32'd0);
    ack(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
